full_adder_checker: RTL

Synthesizable response checker that sits at the output side of the full-adder bench, opposite the stimulus generator. It samples each applied vector (a, b, cin) together with the DUT outputs (sum, carry) over a valid/ready handshake. For each sample it computes the expected result, counts mismatches and records which of the 8 input combinations were exercised. After a programmed number of vectors it reports a single pass/fail verdict.

---
 rtl/full_adder_checker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/full_adder_checker.sv
// full_adder_checker
//
// Response checker for a full-adder bench. Each accepted sample carries an
// applied vector (a, b, cin) and the DUT response (sum, carry). The checker
// compares the response against the full-adder truth table, keeps a
// saturating mismatch count, and records which of the 8 input combinations
// were seen. After NUM_VECTORS accepted samples it reports a pass/fail verdict.
//
// Handshake: a sample is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in RUN and is decoded from registered state, so it
// never depends combinationally on in_valid or on the data inputs. Data inputs
// are ignored whenever no handshake takes place.
//
// Optional build macro: FULL_ADDER_CHECKER_FIRST_FAIL_EN
//   defined   -> first mismatching sample of a run is captured in
//                first_fail_vec / first_fail_valid
//   undefined -> both outputs are tied to 0 and no capture register exists
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            pulse; begins a run from IDLE or DONE
//   in_valid/in_ready sample handshake
//   a, b, cin        applied vector
//   sum, carry       DUT response
//   busy, done       run in progress / run complete
//   pass             verdict, meaningful while done=1
//   err_count        saturating count of mismatched samples this run
//   cov_mask         bit {a,b,cin} set once that combination was accepted
//   first_fail_vec   {a,b,cin,sum,carry} of first mismatch
//   first_fail_valid first_fail_vec holds data
//   dbg_state        current FSM state (0=IDLE, 1=RUN, 2=DONE)
module full_adder_checker #(
    parameter int NUM_VECTORS = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       cov_mask,
    output logic [4:0]       first_fail_vec,
    output logic             first_fail_valid,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] vec_cnt;

    logic hs;
    logic last_hs;
    logic clear_run;
    logic exp_sum;
    logic exp_carry;
    logic mismatch;

    assign hs        = in_valid && (state == RUN);
    assign last_hs   = hs && (vec_cnt == 8'(NUM_VECTORS - 1));
    // start only opens a new run outside RUN; in RUN it is ignored.
    assign clear_run = start && (state != RUN);

    assign exp_sum   = a ^ b ^ cin;
    assign exp_carry = (a & b) | (a & cin) | (b & cin);
    assign mismatch  = (sum != exp_sum) || (carry != exp_carry);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_hs) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: registered state and statistics only.
    always_comb begin
        in_ready  = (state == RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
        pass      = (state == DONE) && (err_count == '0) && (cov_mask == 8'hFF);
        dbg_state = state;
    end

    // Run statistics; they only move on a RUN handshake, so DONE freezes them.
    always_ff @(posedge clk) begin
        if (rst || clear_run) begin
            vec_cnt   <= 8'd0;
            err_count <= '0;
            cov_mask  <= 8'h00;
        end else if (hs) begin
            vec_cnt                <= vec_cnt + 8'd1;
            cov_mask[{a, b, cin}]  <= 1'b1;
            if (mismatch && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

`ifdef FULL_ADDER_CHECKER_FIRST_FAIL_EN
    logic [4:0] ff_vec_q;
    logic       ff_valid_q;

    // Capture only the first mismatch of the run; later ones are dropped.
    always_ff @(posedge clk) begin
        if (rst || clear_run) begin
            ff_vec_q   <= 5'd0;
            ff_valid_q <= 1'b0;
        end else if (hs && mismatch && !ff_valid_q) begin
            ff_vec_q   <= {a, b, cin, sum, carry};
            ff_valid_q <= 1'b1;
        end
    end

    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`else
    assign first_fail_vec   = 5'd0;
    assign first_fail_valid = 1'b0;
`endif

endmodule
